// File: rtl/pixel_bus_writer.sv
// pixel_bus_writer: buffers the Mandelbrot engine's pixel write stream in a
// small FIFO and drains it as an Avalon-MM style write master into the frame
// buffer. Pixel index becomes byte address (BASE_ADDR + index*4) and the 24-bit
// RGB is zero-padded to 32 bits. pix_buswait is registered FIFO back-pressure.
// Optional statistics counters: define PIXEL_WRITER_STATS_EN to add stat_beats
// and stat_stall.
module pixel_bus_writer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
    parameter int          AF_MARGIN = 2,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          pix_wen,
    input  logic [31:0]   pix_addr,
    input  logic [23:0]   pix_rgb,
    output logic          pix_buswait,
    output logic [31:0]   avm_address,
    output logic [31:0]   avm_writedata,
    output logic [3:0]    avm_byteenable,
    output logic          avm_write,
    input  logic          avm_waitrequest,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
`ifdef PIXEL_WRITER_STATS_EN
    ,
    output logic [31:0]   stat_beats,
    output logic [31:0]   stat_stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    // FIFO storage and bookkeeping
    logic [55:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_buswait;
    logic          r_overflow;

    // Bus master state
    logic          r_state;
    logic          r_write;
    logic [31:0]   r_address;
    logic [31:0]   r_writedata;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_nxt;
    logic [55:0]   w_head;
    logic [31:0]   w_head_addr;
    logic [23:0]   w_head_rgb;

    // Pop whenever data is waiting and the output register is free: either idle
    // or the current beat completes on this edge.
    assign w_pop       = (r_count != '0) && ((r_state == ST_IDLE) || !avm_waitrequest);
    // A full FIFO can still accept when the same edge frees a slot.
    assign w_push      = pix_wen && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[55:24];
    assign w_head_rgb  = w_head[23:0];

    // FIFO data array; slot contents are qualified by the pointers
    // NOTE: the storage array is deliberately not reset -- stale slots are never
    // read because r_count gates every pop, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pix_addr, pix_rgb};
        end
    end

    // FIFO pointers, occupancy, back-pressure and sticky overflow flag
    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, as the hardware does.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_buswait  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count   <= w_count_nxt;
            r_buswait <= (w_count_nxt >= CW'(DEPTH - AF_MARGIN));
            if (pix_wen && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // IDLE/WRITE bus master: load output registers on pop, hold while stalled
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
        end else if (w_pop) begin
            r_state     <= ST_WRITE;
            r_write     <= 1'b1;
            r_address   <= BASE_ADDR + (w_head_addr << 2);
            r_writedata <= {8'h00, w_head_rgb};
        end else if ((r_state == ST_WRITE) && !avm_waitrequest) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
        end
    end

`ifdef PIXEL_WRITER_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_stall;

    // Completed-beat and stall-cycle counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_stat_beats <= '0;
            r_stat_stall <= '0;
        end else if (r_write) begin
            if (avm_waitrequest) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end else begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
        end
    end

    assign stat_beats = r_stat_beats;
    assign stat_stall = r_stat_stall;
`endif

    assign pix_buswait    = r_buswait;
    assign avm_address    = r_address;
    assign avm_writedata  = r_writedata;
    assign avm_byteenable = 4'hF;
    assign avm_write      = r_write;
    assign fifo_count     = r_count;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_pixel_bus_writer.sv
// Directed self-checking bench for pixel_bus_writer (DEPTH=8, AF_MARGIN=2).
// Inputs are driven and outputs sampled on the falling edge; a posedge monitor
// records every completed bus beat for order checks.
module tb_pixel_bus_writer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        pix_wen;
    logic [31:0] pix_addr;
    logic [23:0] pix_rgb;
    logic        pix_buswait;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_write;
    logic        avm_waitrequest;
    logic [3:0]  fifo_count;
    logic        overflow;
`ifdef PIXEL_WRITER_STATS_EN
    logic [31:0] stat_beats;
    logic [31:0] stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Beat capture
    logic [31:0] cap_addr [64];
    logic [31:0] cap_data [64];
    int          cap_cyc  [64];
    int          n_beats = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    pixel_bus_writer dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .pix_wen         (pix_wen),
        .pix_addr        (pix_addr),
        .pix_rgb         (pix_rgb),
        .pix_buswait     (pix_buswait),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
`ifdef PIXEL_WRITER_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_stall      (stat_stall)
`endif
    );

    // Record each completed beat (pre-edge values) with its cycle number
    always @(posedge clk) begin
        cyc++;
        if (avm_write && !avm_waitrequest && n_beats < 64) begin
            cap_addr[n_beats] = avm_address;
            cap_data[n_beats] = avm_writedata;
            cap_cyc[n_beats]  = cyc;
            n_beats++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int base;
    int k;
    int max_cnt;
    int bw_seen;

    initial begin
        n_rst           = 1'b1;
        pix_wen         = 1'b0;
        pix_addr        = '0;
        pix_rgb         = '0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        step();
        step();

        // ---- Reset state ----
        check("rst_write",    64'(avm_write), 64'd0);
        check("rst_count",    64'(fifo_count), 64'd0);
        check("rst_addr",     64'(avm_address), 64'd0);
        check("rst_data",     64'(avm_writedata), 64'd0);
        check("rst_buswait",  64'(pix_buswait), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_be",       64'(avm_byteenable), 64'hF);
        n_rst = 1'b0;
        step();

        // ---- Single pixel ----
        base     = n_beats;
        pix_wen  = 1'b1;
        pix_addr = 32'd5;
        pix_rgb  = 24'h12_34_56;
        step();
        pix_wen = 1'b0;
        check("single_e0_write", 64'(avm_write), 64'd0);
        check("single_e0_count", 64'(fifo_count), 64'd1);
        step();
        check("single_e1_write", 64'(avm_write), 64'd1);
        check("single_e1_addr",  64'(avm_address), 64'h0800_0014);
        check("single_e1_data",  64'(avm_writedata), 64'h0012_3456);
        check("single_e1_count", 64'(fifo_count), 64'd0);
        step();
        check("single_e2_write", 64'(avm_write), 64'd0);
        check("single_beats",    64'(n_beats - base), 64'd1);

        // ---- Burst of 20, no stall ----
        base    = n_beats;
        max_cnt = 0;
        bw_seen = 0;
        for (int i = 0; i < 20; i++) begin
            pix_wen  = 1'b1;
            pix_addr = 32'(i);
            pix_rgb  = 24'hA0_00_00 + 24'(i);
            step();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (pix_buswait) bw_seen = 1;
        end
        pix_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (pix_buswait) bw_seen = 1;
        end
        check("burst_beats",   64'(n_beats - base), 64'd20);
        check("burst_maxcnt",  64'(max_cnt), 64'd1);
        check("burst_buswait", 64'(bw_seen), 64'd0);
        check("burst_b2b",     64'(cap_cyc[base + 19] - cap_cyc[base]), 64'd19);
        for (int i = 0; i < 20; i++) begin
            check("burst_addr", 64'(cap_addr[base + i]), 64'(32'h0800_0000 + 32'(4 * i)));
            check("burst_data", 64'(cap_data[base + i]), 64'(32'h00A0_0000 + 32'(i)));
        end

        // ---- Back-pressure, producer honours buswait ----
        avm_waitrequest = 1'b1;
        base = n_beats;
        k    = 0;
        for (int i = 0; i < 12; i++) begin
            pix_wen  = !pix_buswait;
            pix_addr = 32'(100 + k);
            pix_rgb  = 24'h00_00_00 + 24'(k);
            if (pix_wen) k++;
            step();
        end
        pix_wen = 1'b0;
        check("bp_sent",     64'(k), 64'd7);
        check("bp_count",    64'(fifo_count), 64'd6);
        check("bp_buswait",  64'(pix_buswait), 64'd1);
        check("bp_overflow", 64'(overflow), 64'd0);
        check("bp_write",    64'(avm_write), 64'd1);
        check("bp_hold_addr", 64'(avm_address), 64'h0800_0190);
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("bp_beats",     64'(n_beats - base), 64'd7);
        check("bp_buswait_0", 64'(pix_buswait), 64'd0);
        for (int i = 0; i < 7; i++) begin
            check("bp_order", 64'(cap_addr[base + i]), 64'(32'h0800_0000 + 32'(4 * (100 + i))));
        end

        // ---- Overflow, producer ignores buswait ----
        avm_waitrequest = 1'b1;
        base = n_beats;
        for (int i = 0; i < 12; i++) begin
            pix_wen  = 1'b1;
            pix_addr = 32'(200 + i);
            pix_rgb  = 24'h55_00_00 + 24'(i);
            step();
        end
        pix_wen = 1'b0;
        check("ovf_count",    64'(fifo_count), 64'd8);
        check("ovf_flag",     64'(overflow), 64'd1);
        check("ovf_buswait",  64'(pix_buswait), 64'd1);
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("ovf_beats",    64'(n_beats - base), 64'd9);
        check("ovf_sticky",   64'(overflow), 64'd1);
        for (int i = 0; i < 9; i++) begin
            check("ovf_order", 64'(cap_addr[base + i]), 64'(32'h0800_0000 + 32'(4 * (200 + i))));
        end

        // ---- Reset mid-stall ----
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_wen  = 1'b1;
            pix_addr = 32'(300 + i);
            pix_rgb  = 24'h0F_0F_0F;
            step();
        end
        pix_wen = 1'b0;
        check("rms_pre_count", 64'(fifo_count), 64'd4);
        check("rms_pre_write", 64'(avm_write), 64'd1);
        n_rst = 1'b1;
        step();
        check("rms_write",    64'(avm_write), 64'd0);
        check("rms_count",    64'(fifo_count), 64'd0);
        check("rms_buswait",  64'(pix_buswait), 64'd0);
        check("rms_overflow", 64'(overflow), 64'd0);
        n_rst           = 1'b0;
        avm_waitrequest = 1'b0;
        base = n_beats;
        for (int i = 0; i < 6; i++) step();
        check("rms_no_beats", 64'(n_beats - base), 64'd0);

        // ---- Address wrap modulo 2^32 ----
        pix_wen  = 1'b1;
        pix_addr = 32'h3FFF_FFFF;
        pix_rgb  = 24'hFF_EE_DD;
        step();
        pix_wen = 1'b0;
        step();
        check("wrap_write", 64'(avm_write), 64'd1);
        check("wrap_addr",  64'(avm_address), 64'h07FF_FFFC);
        check("wrap_data",  64'(avm_writedata), 64'h00FF_EEDD);
        step();
        step();

`ifdef PIXEL_WRITER_STATS_EN
        // ---- Statistics: waitrequest 1,1,0,0,0 over three beats ----
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_wen  = 1'b1;
            pix_addr = 32'(400 + i);
            pix_rgb  = 24'h01_02_03;
            step();
        end
        pix_wen = 1'b0;
        step();
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("stat_beats", 64'(stat_beats), 64'd3);
        check("stat_stall", 64'(stat_stall), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
